seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Sequential signed divider; the inverse companion of the signed 8x8 shift-add multiplier.
- Divides a signed 2W-bit Dividend (a product-width value) by a signed W-bit Divisor.
- Produces a signed W-bit Quotient and a signed W-bit Remainder, with divide-by-zero and overflow flags.
- Uses the same start/ready handshake as the multiplier, so a bench or datapath can chain multiply-then-divide.

Parameters:
W  8  operand width; Divisor, Quotient and Remainder are W bits, Dividend is 2W bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  start request; operands sampled on the edge where start=1 and ready=1
Dividend  input  2W  signed dividend, two's complement
Divisor  input  W  signed divisor, two's complement
Quotient  output  W  signed quotient, truncated toward zero
Remainder  output  W  signed remainder, sign follows Dividend
div_by_zero  output  1  set when the captured Divisor was 0
overflow  output  1  set when the true quotient lies outside [-2^(W-1), 2^(W-1)-1]
ready  output  1  high when idle and results are valid; low while busy

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; ready=1; Quotient, Remainder, div_by_zero and overflow all 0.
  - Reset overrides start and aborts any operation in flight; the partial result is discarded.
- IDLE, start=1 at edge E0:
  - Register |Dividend| (2W bits), |Divisor| (W bits), sign_q = sign(Dividend) XOR sign(Divisor), sign_r = sign(Dividend), and zero flag = (Divisor==0).
  - Go to CALC with count=0; ready=0 from E0.
  - Operands may change or go X after E0.
- start while ready=0 is ignored; no queueing.
- CALC: one restoring step per cycle, 2W cycles total.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - If partial remainder >= |Divisor|, subtract and set the quotient bit to 1; else set it to 0.
  - Partial remainder is W+1 bits; quotient magnitude is 2W bits.
  - After the step with count=2W-1, go to FIX.
- FIX (one cycle):
  - Apply signs: Quotient = low W bits of (sign_q ? -qmag : qmag); Remainder = sign_r ? -rmag : rmag.
  - overflow=1 if the signed 2W-bit quotient is outside the W-bit signed range; Quotient is still the truncated low W bits.
  - If the zero flag is set: Quotient=0, Remainder=0, div_by_zero=1, overflow=0.
  - Otherwise div_by_zero=0.
  - Go to IDLE.
- Latency is fixed at 2W+2 edges after E0, the same for divide-by-zero.
  - At edge E0+2W+2, ready=1 and all outputs are valid (W=8: edge E0+18).
- Outputs hold their values until the FIX of the next operation.
  - During busy cycles the outputs keep the previous result; only ready marks validity.
- A start asserted in the same cycle ready returns to 1 is accepted (back-to-back operation).
- Arithmetic rules:
  - Magnitude of -2^(2W-1) is 2^(2W-1), held in 2W unsigned bits.
  - Magnitude of -2^(W-1) is 2^(W-1), held in W unsigned bits.
  - Remainder magnitude is always < 2^(W-1), so it always fits.
  - Results match Verilog signed / and % for all non-overflow, non-zero cases.

Decomposition:
- Package seq_divider_pkg:
  - state encoding localparams IDLE, CALC, FIX;
  - count width function clog2(2W).
- One combinational sub-module div_step:
  - inputs: partial remainder, next dividend bit, divisor magnitude;
  - outputs: next partial remainder, quotient bit.
- Top-level holds the FSM, registers, and the sign/flag fix-up.

Test Plan:
- Inverse of multiplier: for 100 random signed 8-bit A and nonzero B, Dividend = A*B, Divisor = B -> Quotient = A, Remainder = 0, overflow = 0, ready high exactly 18 edges after start.
- Sign rules: Dividend=-7, Divisor=2 -> Quotient=-3 (0xFD), Remainder=-1 (0xFF). Dividend=7, Divisor=-2 -> Quotient=-3, Remainder=1.
- Boundary values:
  - Dividend=-32768, Divisor=-128 -> Quotient=0x00, overflow=1 (true quotient 256).
  - Dividend=-16384, Divisor=-128 -> Quotient=0x80, overflow=1 (true quotient 128).
  - Dividend=16256, Divisor=-128 -> Quotient=-127 (0x81), Remainder=0, overflow=0.
- Divide by zero: Dividend=1234, Divisor=0 -> div_by_zero=1, Quotient=0, Remainder=0, overflow=0, same 18-edge latency; the next valid division clears div_by_zero.
- Handshake: a start pulse mid-CALC is ignored and the result is unchanged. A start on the cycle ready rises is accepted, and ready drops on that edge.
- Reset mid-operation: rst_n=0 for one edge at count=5 -> next cycle ready=1 and all outputs 0. A subsequent start with 100/7 -> Quotient=14, Remainder=2.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding and a
// constant-width helper.
package seq_divider_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division step: shift in the next dividend bit, subtract the
// divisor magnitude when it fits.
module div_step #(
   parameter int W = 8
) (
   input  logic [W:0]   rem,
   input  logic         din,
   input  logic [W-1:0] dmag,
   output logic [W:0]   rem_nx,
   output logic         qbit
);

   logic [W:0] sh;

   assign sh = {rem[W-1:0], din};

   // A set top bit means the shifted value already exceeds any W-bit divisor.
   always_comb begin
      qbit   = rem[W] | (sh >= {1'b0, dmag});
      rem_nx = qbit ? (sh - {1'b0, dmag}) : sh;
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed 2W/W divider with start/ready handshake, fixed 2W+2 edge
// latency, divide-by-zero and quotient-overflow flags.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*W-1:0] Dividend,
   input  logic [W-1:0]   Divisor,
   output logic [W-1:0]   Quotient,
   output logic [W-1:0]   Remainder,
   output logic           div_by_zero,
   output logic           overflow,
   output logic           ready
);

   localparam int CW = clog2(2*W);
   localparam logic [CW-1:0]  LAST = CW'(2*W-1);
   localparam logic [2*W-1:0] QLIM = (2*W)'(1) << (W-1);

   state_t         state, state_nx;
   logic [CW-1:0]  count;
   logic [2*W-1:0] dq;       // dividend bits shift out the top, quotient bits in the bottom
   logic [W:0]     rem, rem_nx;
   logic [W-1:0]   dmag;
   logic           sign_q, sign_r, zero, qbit, pub;
   logic [W-1:0]   res_q, res_r, q_fix, r_fix;
   logic           res_dz, res_ov, ov_fix;
   logic           accept;

   assign accept = (state == IDLE) && start && ready;

   div_step #(.W(W)) u_step (
      .rem    (rem),
      .din    (dq[2*W-1]),
      .dmag   (dmag),
      .rem_nx (rem_nx),
      .qbit   (qbit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = CALC;
         CALC:    if (count == LAST) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Sign fix-up; a negative quotient may reach magnitude 2^(W-1), a positive one may not.
   always_comb begin
      q_fix  = sign_q ? -dq[W-1:0] : dq[W-1:0];
      r_fix  = sign_r ? -rem[W-1:0] : rem[W-1:0];
      ov_fix = sign_q ? (dq > QLIM) : (dq >= QLIM);
   end

   // Results land in res_* on the FIX edge and are published one edge later,
   // so the outputs and ready change together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready       <= 1'b1;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         pub         <= 1'b0;
         count       <= '0;
         dq          <= '0;
         rem         <= '0;
         dmag        <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero        <= 1'b0;
         res_q       <= '0;
         res_r       <= '0;
         res_dz      <= 1'b0;
         res_ov      <= 1'b0;
      end else begin
         pub <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               dq     <= Dividend[2*W-1] ? -Dividend : Dividend;
               dmag   <= Divisor[W-1] ? -Divisor : Divisor;
               rem    <= '0;
               sign_q <= Dividend[2*W-1] ^ Divisor[W-1];
               sign_r <= Dividend[2*W-1];
               zero   <= (Divisor == '0);
               count  <= '0;
               ready  <= 1'b0;
            end
            CALC: begin
               dq    <= {dq[2*W-2:0], qbit};
               rem   <= rem_nx;
               count <= count + 1'b1;
            end
            FIX: begin
               res_q  <= zero ? '0 : q_fix;
               res_r  <= zero ? '0 : r_fix;
               res_dz <= zero;
               res_ov <= zero ? 1'b0 : ov_fix;
               pub    <= 1'b1;
            end
            default: ;
         endcase
         if (pub) begin
            Quotient    <= res_q;
            Remainder   <= res_r;
            div_by_zero <= res_dz;
            overflow    <= res_ov;
            ready       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic model from signed / and %, a
// per-cycle output compare, and hand-computed literal checks.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [15:0] Dividend;
   logic [7:0]  Divisor;
   logic [7:0]  Quotient, Remainder;
   logic        div_by_zero, overflow, ready;

   int          vectors = 0;
   int          errors  = 0;
   logic [7:0]  exp_q, exp_r;
   logic        exp_dz, exp_ov;
   bit          exp_valid = 1'b0;

   seq_divider #(.W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .Dividend    (Dividend),
      .Divisor     (Divisor),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow),
      .ready       (ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected results straight from signed integer division.
   task automatic model(input logic [15:0] dvd, input logic [7:0] dvs);
      longint a, b, q, r;
      a = longint'($signed(dvd));
      b = longint'($signed(dvs));
      if (b == 0) begin
         exp_q = 8'h00; exp_r = 8'h00; exp_dz = 1'b1; exp_ov = 1'b0;
      end else begin
         q = a / b;
         r = a % b;
         exp_q  = q[7:0];
         exp_r  = r[7:0];
         exp_dz = 1'b0;
         exp_ov = (q > 127) || (q < -128);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && ready && exp_valid) begin
         chk("cmp_quotient",  {24'h0, Quotient},  {24'h0, exp_q});
         chk("cmp_remainder", {24'h0, Remainder}, {24'h0, exp_r});
         chk("cmp_dz",        {31'h0, div_by_zero}, {31'h0, exp_dz});
         chk("cmp_ov",        {31'h0, overflow},  {31'h0, exp_ov});
      end
   end

   // Issue one division as soon as ready is high; optionally pulse start
   // again glitch_at edges into the operation.
   task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs, input int glitch_at);
      int n, lat;
      n = 0;
      while (!ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("ready_wait", {31'h0, ready}, 32'h1);
      Dividend = dvd; Divisor = dvs; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      Dividend = 16'($urandom); Divisor = 8'($urandom);
      model(dvd, dvs);
      chk("ready_drop", {31'h0, ready}, 32'h0);
      lat = 0;
      while (!ready && lat < 40) begin
         start = (lat == glitch_at);
         @(posedge clk); #1; lat++;
      end
      start = 1'b0;
      chk("latency", lat, 32'd18);
   endtask

   initial begin
      logic [7:0] a, b;
      int pa, pb;
      rst_n = 1'b0; start = 1'b0; Dividend = '0; Divisor = '0;
      exp_q = '0; exp_r = '0; exp_dz = 1'b0; exp_ov = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_ready", {31'h0, ready}, 32'h1);
      chk("rst_q", {24'h0, Quotient}, 32'h0);
      chk("rst_r", {24'h0, Remainder}, 32'h0);
      chk("rst_flags", {30'h0, div_by_zero, overflow}, 32'h0);
      exp_valid = 1'b1;

      // sign rules
      run_div(-16'sd7, 8'sd2, -1);
      chk("lit_m7_2_q", {24'h0, Quotient}, 32'hFD);
      chk("lit_m7_2_r", {24'h0, Remainder}, 32'hFF);
      run_div(16'sd7, -8'sd2, -1);
      chk("lit_7_m2_q", {24'h0, Quotient}, 32'hFD);
      chk("lit_7_m2_r", {24'h0, Remainder}, 32'h01);

      // boundaries
      run_div(16'h8000, 8'h80, -1);
      chk("lit_min_q", {24'h0, Quotient}, 32'h00);
      chk("lit_min_ov", {31'h0, overflow}, 32'h1);
      run_div(-16'sd16384, 8'h80, -1);
      chk("lit_128_q", {24'h0, Quotient}, 32'h80);
      chk("lit_128_ov", {31'h0, overflow}, 32'h1);
      run_div(16'sd16256, 8'h80, -1);
      chk("lit_m127_q", {24'h0, Quotient}, 32'h81);
      chk("lit_m127_ov", {31'h0, overflow}, 32'h0);

      // divide by zero, then a normal division clears the flag
      run_div(16'd1234, 8'd0, -1);
      chk("lit_dz", {31'h0, div_by_zero}, 32'h1);
      chk("lit_dz_q", {24'h0, Quotient}, 32'h0);
      run_div(16'd100, 8'd7, -1);
      chk("lit_dz_clear", {31'h0, div_by_zero}, 32'h0);

      // start pulse mid-CALC must be ignored
      run_div(16'd1000, 8'd9, 5);
      chk("lit_glitch_q", {24'h0, Quotient}, 32'd111);
      chk("lit_glitch_r", {24'h0, Remainder}, 32'd1);

      // inverse of the multiplier, issued back to back
      for (int i = 0; i < 100; i++) begin
         a = 8'($urandom);
         do b = 8'($urandom); while (b == 8'h00);
         pa = int'($signed(a));
         pb = int'($signed(b));
         run_div(16'(pa * pb), b, -1);
         chk("inv_q", {24'h0, Quotient}, {24'h0, a});
         chk("inv_r", {24'h0, Remainder}, 32'h0);
      end

      // reset during CALC at count=5
      Dividend = 16'd5000; Divisor = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_q = '0; exp_r = '0; exp_dz = 1'b0; exp_ov = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_ready", {31'h0, ready}, 32'h1);
      chk("abort_q", {24'h0, Quotient}, 32'h0);
      chk("abort_r", {24'h0, Remainder}, 32'h0);
      chk("abort_flags", {30'h0, div_by_zero, overflow}, 32'h0);
      run_div(16'd100, 8'd7, -1);
      chk("lit_100_7_q", {24'h0, Quotient}, 32'd14);
      chk("lit_100_7_r", {24'h0, Remainder}, 32'd2);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
